// File: rtl/usb_seq_pkg.sv
// Shared state encoding, PID constants and helpers for the USB transmit packet sequencer.
package usb_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    WAIT_PID,
    HOLD,
    FETCH,
    WAIT_DATA,
    WAIT_LAST,
    DRAIN
  } seq_state_t;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;

  localparam int DEF_TIMEOUT = 64;

  // States in which the sequencer is blocked on usb_top and the watchdog runs.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == WAIT_PID) || (s == WAIT_DATA) || (s == WAIT_LAST) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/usb_seq_timer.sv
// Clearable saturating cycle counter; o_tc is high once the count sits at TIMEOUT-1.
// Clear has priority over enable; the count holds at terminal value until cleared.
module usb_seq_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int            CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TC)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/usb_tx_sequencer.sv
// Packet-level driver for the usb_top transmit handshake: PID, buffered payload, last-byte, drain.
// Every output is registered; waits on tx_ready_ld / t_lastbit are bounded by a TIMEOUT watchdog.
module usb_tx_sequencer
  import usb_seq_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 6,
  parameter int LEN_W   = 7,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              gclk,
  input  logic              reset_l,
  input  logic              start,
  input  logic [7:0]        pid,
  input  logic [LEN_W-1:0]  len,
  input  logic              crc16_sel,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_len,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic              syn_gen_ld,
  output logic              crc_16,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  output logic              tx_last_byte,
  input  logic              tx_ready_ld,
  input  logic              t_lastbit
);

  seq_state_t        r_state, w_state_nxt;

  logic [7:0]        r_pid;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [7:0]        r_hold;
  logic              r_hold_vld;
  logic              r_crc16;

  logic              r_busy, r_done, r_err_to, r_err_len;
  logic              r_buf_rd_en, r_syn_gen_ld, r_tx_load, r_tx_last;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [7:0]        r_tx_data;

  logic              w_busy_nxt, w_done_nxt, w_err_to_nxt, w_err_len_nxt;
  logic              w_buf_rd_en_nxt, w_syn_gen_ld_nxt, w_tx_load_nxt, w_tx_last_nxt;
  logic [ADDR_W-1:0] w_buf_addr_nxt;
  logic [7:0]        w_tx_data_nxt;
  logic              w_accept, w_inc;
  logic              w_tc, w_expired, w_tmr_clr, w_tmr_en;
  logic [7:0]        w_byte;

  // The buffer answers one cycle after the read; bypass the holding register on that first cycle.
  assign w_byte    = r_hold_vld ? r_hold : buf_data;
  assign w_tmr_en  = is_wait_state(r_state);
  assign w_expired = w_tmr_en && w_tc;
  assign w_tmr_clr = (w_state_nxt != r_state) && is_wait_state(w_state_nxt);

  usb_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk   (gclk),
    .i_rst_n (reset_l),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_err_to_nxt     = 1'b0;
    w_err_len_nxt    = 1'b0;
    w_buf_rd_en_nxt  = 1'b0;
    w_syn_gen_ld_nxt = 1'b0;
    w_tx_load_nxt    = 1'b0;
    w_tx_last_nxt    = 1'b0;
    w_buf_addr_nxt   = r_buf_addr;
    w_tx_data_nxt    = r_tx_data;
    w_accept         = 1'b0;
    w_inc            = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (len <= LEN_W'(MAX_LEN)) begin
            w_accept         = 1'b1;
            w_state_nxt      = SYNC;
            w_busy_nxt       = 1'b1;
            w_syn_gen_ld_nxt = 1'b1;
          end else begin
            w_err_len_nxt = 1'b1;
          end
        end
      end
      SYNC: w_state_nxt = WAIT_PID;
      WAIT_PID: begin
        if (tx_ready_ld) begin
          w_tx_load_nxt = 1'b1;
          w_tx_data_nxt = r_pid;
          w_state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (r_idx < r_len) begin
          w_state_nxt     = FETCH;
          w_buf_rd_en_nxt = 1'b1;
          w_buf_addr_nxt  = r_idx[ADDR_W-1:0];
        end else begin
          w_state_nxt = WAIT_LAST;
        end
      end
      FETCH: w_state_nxt = WAIT_DATA;
      WAIT_DATA: begin
        if (tx_ready_ld) begin
          w_tx_load_nxt = 1'b1;
          w_tx_data_nxt = w_byte;
          w_inc         = 1'b1;
          w_state_nxt   = HOLD;
        end
      end
      WAIT_LAST: begin
        if (tx_ready_ld) begin
          w_tx_last_nxt = 1'b1;
          w_state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        if (t_lastbit) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Watchdog outranks the handshake it was guarding.
    if (w_expired) begin
      w_state_nxt   = IDLE;
      w_busy_nxt    = 1'b0;
      w_err_to_nxt  = 1'b1;
      w_tx_load_nxt = 1'b0;
      w_tx_last_nxt = 1'b0;
      w_done_nxt    = 1'b0;
      w_inc         = 1'b0;
      w_tx_data_nxt = r_tx_data;
    end

    if (abort && (r_state != IDLE)) begin
      w_state_nxt      = IDLE;
      w_busy_nxt       = 1'b0;
      w_done_nxt       = 1'b0;
      w_err_to_nxt     = 1'b0;
      w_buf_rd_en_nxt  = 1'b0;
      w_syn_gen_ld_nxt = 1'b0;
      w_tx_load_nxt    = 1'b0;
      w_tx_last_nxt    = 1'b0;
      w_buf_addr_nxt   = r_buf_addr;
      w_tx_data_nxt    = r_tx_data;
      w_inc            = 1'b0;
    end
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_to     <= 1'b0;
      r_err_len    <= 1'b0;
      r_buf_rd_en  <= 1'b0;
      r_syn_gen_ld <= 1'b0;
      r_tx_load    <= 1'b0;
      r_tx_last    <= 1'b0;
      r_buf_addr   <= '0;
      r_tx_data    <= 8'h00;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_err_to     <= w_err_to_nxt;
      r_err_len    <= w_err_len_nxt;
      r_buf_rd_en  <= w_buf_rd_en_nxt;
      r_syn_gen_ld <= w_syn_gen_ld_nxt;
      r_tx_load    <= w_tx_load_nxt;
      r_tx_last    <= w_tx_last_nxt;
      r_buf_addr   <= w_buf_addr_nxt;
      r_tx_data    <= w_tx_data_nxt;
    end
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      r_pid      <= 8'h00;
      r_len      <= '0;
      r_idx      <= '0;
      r_crc16    <= 1'b0;
      r_hold     <= 8'h00;
      r_hold_vld <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pid   <= pid;
        r_len   <= len;
        r_crc16 <= crc16_sel;
        r_idx   <= '0;
      end else if (w_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == FETCH) begin
        r_hold_vld <= 1'b0;
      end else if ((r_state == WAIT_DATA) && !r_hold_vld) begin
        r_hold     <= buf_data;
        r_hold_vld <= 1'b1;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign err_timeout  = r_err_to;
  assign err_len      = r_err_len;
  assign buf_rd_en    = r_buf_rd_en;
  assign buf_addr     = r_buf_addr;
  assign syn_gen_ld   = r_syn_gen_ld;
  assign crc_16       = r_crc16;
  assign tx_load      = r_tx_load;
  assign tx_data      = r_tx_data;
  assign tx_last_byte = r_tx_last;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer with a pulsing usb_top model and a synchronous byte buffer.
module tb_usb_tx_sequencer;
  import usb_seq_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int ADDR_W  = 6;
  localparam int LEN_W   = 7;
  localparam int TIMEOUT = 64;

  logic              gclk = 1'b0;
  logic              reset_l = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        pid = 8'h00;
  logic [LEN_W-1:0]  len = '0;
  logic              crc16_sel = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done, err_timeout, err_len, buf_rd_en;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_data;
  logic              syn_gen_ld, crc_16, tx_load, tx_last_byte;
  logic [7:0]        tx_data;
  logic              tx_ready_ld, t_lastbit;

  logic              rdy_en = 1'b0;
  logic [7:0]        mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0, n_syn = 0, n_last = 0, n_done = 0, n_errt = 0, n_errl = 0;
  int last_cyc = 0, done_cyc = 0, errt_cyc = 0, rd_cyc = 0;
  logic busy_at_done = 1'b0, busy_at_errt = 1'b0;
  logic [7:0]        load_q [$];
  logic              load_crc_q [$];
  logic [ADDR_W-1:0] addr_q [$];

  logic [22:0] all_outs;
  assign all_outs = {busy, done, err_timeout, err_len, buf_rd_en, buf_addr,
                     syn_gen_ld, crc_16, tx_load, tx_data, tx_last_byte};

  always #5 gclk = ~gclk;

  usb_tx_sequencer #(
    .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .gclk(gclk), .reset_l(reset_l), .start(start), .pid(pid), .len(len),
    .crc16_sel(crc16_sel), .abort(abort), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_len(err_len), .buf_rd_en(buf_rd_en),
    .buf_addr(buf_addr), .buf_data(buf_data), .syn_gen_ld(syn_gen_ld),
    .crc_16(crc_16), .tx_load(tx_load), .tx_data(tx_data),
    .tx_last_byte(tx_last_byte), .tx_ready_ld(tx_ready_ld), .t_lastbit(t_lastbit)
  );

  // usb_top + buffer model: ready pulse every 8 cycles, T_lastbit 4 cycles after TX_LAST_BYTE.
  initial begin : usb_model
    int pcnt;
    int dly;
    logic prev_rd;
    logic [ADDR_W-1:0] prev_addr;
    pcnt = 0; dly = 0; prev_rd = 1'b0; prev_addr = '0;
    tx_ready_ld = 1'b0; t_lastbit = 1'b0; buf_data = 8'h00;
    forever begin
      @(posedge gclk); #1;
      if (prev_rd) buf_data = mem[prev_addr];
      prev_rd   = buf_rd_en;
      prev_addr = buf_addr;
      pcnt++;
      tx_ready_ld = rdy_en && (pcnt % 8 == 0);
      t_lastbit = (dly == 1);
      if (dly > 0) dly--;
      if (tx_last_byte) dly = 4;
    end
  end

  initial begin : monitor
    forever begin
      @(posedge gclk); #3;
      cyc++;
      if (tx_load) begin
        load_q.push_back(tx_data);
        load_crc_q.push_back(crc_16);
      end
      if (buf_rd_en) begin
        addr_q.push_back(buf_addr);
        rd_cyc = cyc;
      end
      if (syn_gen_ld) n_syn++;
      if (tx_last_byte) begin n_last++; last_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
      if (err_timeout) begin n_errt++; errt_cyc = cyc; busy_at_errt = busy; end
      if (err_len) n_errl++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ld_at(input int i);
    if (i < load_q.size()) return load_q[i];
    return 8'hxx;
  endfunction

  function automatic logic [ADDR_W-1:0] ad_at(input int i);
    if (i < addr_q.size()) return addr_q[i];
    return 'x;
  endfunction

  task automatic pulse_start(input logic [7:0] p, input logic [LEN_W-1:0] l, input logic c);
    pid = p; len = l; crc16_sel = c; start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input string tag);
    for (int i = 0; i < 3000 && !(n_done > d0 || n_errt > e0); i++) @(negedge gclk);
    n_checks++;
    if (!(n_done > d0 || n_errt > e0)) begin
      n_errors++;
      $display("FAIL %s_end: no done/err_timeout within 3000 cycles (done=%0d errt=%0d)", tag, n_done, n_errt);
    end
    repeat (2) @(negedge gclk);
  endtask

  task automatic test_reset;
    n_checks++;
    if (all_outs !== 23'd0) begin
      n_errors++; $display("FAIL reset_hold: outputs=%h expected 0", all_outs);
    end
    reset_l = 1'b1;
    repeat (3) @(negedge gclk);
    n_checks++;
    if (all_outs !== 23'd0 || n_errl != 0 || n_errt != 0) begin
      n_errors++; $display("FAIL reset_release: outputs=%h errl=%0d errt=%0d expected all 0", all_outs, n_errl, n_errt);
    end
  endtask

  task automatic test_basic;
    int l0, a0, s0, t0, d0, e0;
    logic crc_ok;
    mem[0] = 8'h3F; mem[1] = 8'hB4;
    l0 = load_q.size(); a0 = addr_q.size(); s0 = n_syn; t0 = n_last; d0 = n_done; e0 = n_errt;
    rdy_en = 1'b1;
    pulse_start(PID_DATA0, 7'd2, 1'b1);
    n_checks++;
    if (busy !== 1'b1 || syn_gen_ld !== 1'b1) begin
      n_errors++; $display("FAIL basic_accept: busy=%b syn_gen_ld=%b expected 1 1", busy, syn_gen_ld);
    end
    wait_end(d0, e0, "basic");
    n_checks++;
    if (n_syn - s0 != 1) begin n_errors++; $display("FAIL basic_syn: got %0d syn pulses expected 1", n_syn - s0); end
    n_checks++;
    if (load_q.size() - l0 != 3 || ld_at(l0) !== 8'hC3 || ld_at(l0+1) !== 8'h3F || ld_at(l0+2) !== 8'hB4) begin
      n_errors++;
      $display("FAIL basic_bytes: n=%0d bytes %h %h %h expected 3 bytes c3 3f b4",
               load_q.size() - l0, ld_at(l0), ld_at(l0+1), ld_at(l0+2));
    end
    crc_ok = 1'b1;
    for (int i = l0; i < load_crc_q.size(); i++) if (load_crc_q[i] !== 1'b1) crc_ok = 1'b0;
    n_checks++;
    if (crc_ok !== 1'b1 || crc_16 !== 1'b1) begin
      n_errors++; $display("FAIL basic_crc16: crc during loads ok=%b now=%b expected 1", crc_ok, crc_16);
    end
    n_checks++;
    if (addr_q.size() - a0 != 2 || ad_at(a0) !== 6'd0 || ad_at(a0+1) !== 6'd1) begin
      n_errors++; $display("FAIL basic_addr: n=%0d addrs %0d %0d expected 0 1", addr_q.size() - a0, ad_at(a0), ad_at(a0+1));
    end
    n_checks++;
    if (n_last - t0 != 1 || n_done - d0 != 1 || n_errt != e0) begin
      n_errors++; $display("FAIL basic_end: last=%0d done=%0d errt=%0d expected 1 1 0", n_last - t0, n_done - d0, n_errt - e0);
    end
    n_checks++;
    if (done_cyc - last_cyc != 5 || busy_at_done !== 1'b0) begin
      n_errors++; $display("FAIL basic_drain: done %0d cycles after last_byte busy=%b expected 5 0", done_cyc - last_cyc, busy_at_done);
    end
  endtask

  task automatic test_zero_len;
    int l0, a0, t0, d0, e0;
    l0 = load_q.size(); a0 = addr_q.size(); t0 = n_last; d0 = n_done; e0 = n_errt;
    pulse_start(PID_IN, 7'd0, 1'b0);
    wait_end(d0, e0, "zero");
    n_checks++;
    if (addr_q.size() != a0) begin n_errors++; $display("FAIL zero_no_read: got %0d reads expected 0", addr_q.size() - a0); end
    n_checks++;
    if (load_q.size() - l0 != 1 || ld_at(l0) !== 8'h69) begin
      n_errors++; $display("FAIL zero_pid: n=%0d byte %h expected 1 byte 69", load_q.size() - l0, ld_at(l0));
    end
    n_checks++;
    if (n_last - t0 != 1 || n_done - d0 != 1 || crc_16 !== 1'b0) begin
      n_errors++; $display("FAIL zero_end: last=%0d done=%0d crc_16=%b expected 1 1 0", n_last - t0, n_done - d0, crc_16);
    end
  endtask

  task automatic test_timeout;
    int l0, t0, d0, e0;
    mem[0] = 8'h11; mem[1] = 8'h22;
    l0 = load_q.size(); t0 = n_last; d0 = n_done; e0 = n_errt;
    rdy_en = 1'b1;
    pulse_start(PID_DATA1, 7'd2, 1'b1);
    for (int i = 0; i < 200 && load_q.size() <= l0; i++) @(negedge gclk);
    rdy_en = 1'b0;
    n_checks++;
    if (load_q.size() <= l0) begin n_errors++; $display("FAIL to_pid: PID load missing within 200 cycles"); end
    wait_end(d0, e0, "to");
    n_checks++;
    if (n_errt - e0 != 1 || errt_cyc - rd_cyc != TIMEOUT + 1) begin
      n_errors++; $display("FAIL to_timing: errt=%0d at %0d cycles after WAIT_DATA entry expected 1 at %0d",
                           n_errt - e0, errt_cyc - rd_cyc - 1, TIMEOUT);
    end
    n_checks++;
    if (n_last != t0 || n_done != d0 || load_q.size() - l0 != 1) begin
      n_errors++; $display("FAIL to_no_last: last=%0d done=%0d loads=%0d expected 0 0 1", n_last - t0, n_done - d0, load_q.size() - l0);
    end
    n_checks++;
    if (busy_at_errt !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL to_busy: busy at err=%b after=%b expected 0 0", busy_at_errt, busy);
    end
    rdy_en = 1'b1;
  endtask

  task automatic test_abort;
    int l0, t0, d0, e0, r0;
    mem[0] = 8'hA1; mem[1] = 8'hA2; mem[2] = 8'hA3; mem[3] = 8'hA4;
    l0 = load_q.size(); t0 = n_last; d0 = n_done; e0 = n_errt; r0 = n_errl;
    pulse_start(PID_DATA0, 7'd4, 1'b1);
    for (int i = 0; i < 200 && load_q.size() < l0 + 2; i++) @(negedge gclk);
    @(negedge gclk);
    abort = 1'b1;
    @(negedge gclk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || {syn_gen_ld, tx_load, tx_last_byte, buf_rd_en, done, err_timeout, err_len} !== 7'd0) begin
      n_errors++; $display("FAIL abort_idle: busy=%b strobes=%b expected 0 0000000", busy,
                           {syn_gen_ld, tx_load, tx_last_byte, buf_rd_en, done, err_timeout, err_len});
    end
    repeat (100) @(negedge gclk);
    n_checks++;
    if (n_done != d0 || n_errt != e0 || n_errl != r0 || n_last != t0 || load_q.size() - l0 != 2) begin
      n_errors++; $display("FAIL abort_quiet: done=%0d errt=%0d errl=%0d last=%0d loads=%0d expected 0 0 0 0 2",
                           n_done - d0, n_errt - e0, n_errl - r0, n_last - t0, load_q.size() - l0);
    end
    l0 = load_q.size(); d0 = n_done;
    pulse_start(PID_DATA1, 7'd3, 1'b1);
    wait_end(d0, e0, "abort_restart");
    n_checks++;
    if (load_q.size() - l0 != 4 || ld_at(l0) !== 8'h4B || ld_at(l0+1) !== 8'hA1 || ld_at(l0+2) !== 8'hA2 ||
        ld_at(l0+3) !== 8'hA3 || n_done - d0 != 1) begin
      n_errors++; $display("FAIL abort_restart: n=%0d bytes %h %h %h %h done=%0d expected 4b a1 a2 a3 done 1",
                           load_q.size() - l0, ld_at(l0), ld_at(l0+1), ld_at(l0+2), ld_at(l0+3), n_done - d0);
    end
  endtask

  task automatic test_len_err_and_ignore;
    int l0, d0, e0, r0;
    r0 = n_errl; e0 = n_errt;
    pulse_start(PID_OUT, 7'd65, 1'b0);
    n_checks++;
    if (err_len !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL lenerr_pulse: err_len=%b busy=%b expected 1 0", err_len, busy);
    end
    @(negedge gclk);
    n_checks++;
    if (err_len !== 1'b0 || busy !== 1'b0 || n_errl - r0 != 1) begin
      n_errors++; $display("FAIL lenerr_width: err_len=%b busy=%b count=%0d expected 0 0 1", err_len, busy, n_errl - r0);
    end
    mem[0] = 8'h5A;
    l0 = load_q.size(); d0 = n_done; r0 = n_errl;
    pulse_start(PID_DATA1, 7'd1, 1'b1);
    repeat (3) @(negedge gclk);
    pulse_start(PID_OUT, 7'd70, 1'b0);
    wait_end(d0, e0, "ignore");
    n_checks++;
    if (load_q.size() - l0 != 2 || ld_at(l0) !== 8'h4B || ld_at(l0+1) !== 8'h5A) begin
      n_errors++; $display("FAIL ignore_bytes: n=%0d bytes %h %h expected 4b 5a", load_q.size() - l0, ld_at(l0), ld_at(l0+1));
    end
    n_checks++;
    if (n_errl != r0 || n_done - d0 != 1 || crc_16 !== 1'b1 || n_errt != e0) begin
      n_errors++; $display("FAIL ignore_end: errl=%0d done=%0d crc_16=%b errt=%0d expected 0 1 1 0",
                           n_errl - r0, n_done - d0, crc_16, n_errt - e0);
    end
  endtask

  task automatic test_async_reset;
    int l0, a0, d0, e0;
    mem[0] = 8'hC0; mem[1] = 8'hC1; mem[2] = 8'hC2;
    a0 = addr_q.size();
    rdy_en = 1'b1;
    pulse_start(PID_DATA0, 7'd3, 1'b1);
    for (int i = 0; i < 300 && addr_q.size() < a0 + 2; i++) @(negedge gclk);
    rdy_en = 1'b0;
    repeat (2) @(negedge gclk);
    n_checks++;
    if (busy !== 1'b1 || buf_addr !== 6'd1 || tx_data !== 8'hC0) begin
      n_errors++; $display("FAIL rst_pre: busy=%b buf_addr=%0d tx_data=%h expected 1 1 c0", busy, buf_addr, tx_data);
    end
    #2 reset_l = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== 23'd0) begin
      n_errors++; $display("FAIL rst_async: outputs=%h expected 0", all_outs);
    end
    @(negedge gclk);
    reset_l = 1'b1;
    rdy_en = 1'b1;
    @(negedge gclk);
    l0 = load_q.size(); a0 = addr_q.size(); d0 = n_done; e0 = n_errt;
    pulse_start(PID_IN, 7'd2, 1'b0);
    wait_end(d0, e0, "rst_after");
    n_checks++;
    if (addr_q.size() - a0 != 2 || ad_at(a0) !== 6'd0 || ad_at(a0+1) !== 6'd1) begin
      n_errors++; $display("FAIL rst_addr: n=%0d addrs %0d %0d expected 0 1", addr_q.size() - a0, ad_at(a0), ad_at(a0+1));
    end
    n_checks++;
    if (load_q.size() - l0 != 3 || ld_at(l0) !== 8'h69 || ld_at(l0+1) !== 8'hC0 || ld_at(l0+2) !== 8'hC1 || n_done - d0 != 1) begin
      n_errors++; $display("FAIL rst_packet: n=%0d bytes %h %h %h done=%0d expected 69 c0 c1 done 1",
                           load_q.size() - l0, ld_at(l0), ld_at(l0+1), ld_at(l0+2), n_done - d0);
    end
  endtask

  initial begin : main
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (3) @(negedge gclk);
    test_reset;
    test_basic;
    test_zero_len;
    test_timeout;
    test_abort;
    test_len_err_and_ignore;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_tx_sequencer.md
Name: usb_tx_sequencer

Overview:
Packet-level controller for the usb_top transmit path. It accepts a packet request (PID, payload length, CRC mode) and fetches payload bytes from a synchronous byte buffer. It then sequences usb_top's SYN_GEN_LD / TX_LOAD / TX_LAST_BYTE handshake so that firmware no longer hand-paces bytes against TX_READY_LD. It sits between the endpoint buffer logic and usb_top.

Parameters:
MAX_LEN, 64, maximum payload bytes per packet (excludes PID)
ADDR_W, 6, buffer address width; must satisfy 2**ADDR_W >= MAX_LEN
LEN_W, 7, width of len; must hold MAX_LEN
TIMEOUT, 64, cycles allowed waiting on tx_ready_ld or t_lastbit before abort with error

Ports:
gclk  in  1  system clock, all logic on rising edge
reset_l  in  1  asynchronous active-low reset
start  in  1  one-cycle packet request; sampled only in IDLE
pid  in  8  PID byte, latched on accepted start
len  in  LEN_W  payload byte count 0..MAX_LEN, latched on accepted start
crc16_sel  in  1  1 = CRC16 (data packet), 0 = CRC5 (token); latched on accepted start
abort  in  1  synchronous cancel; highest priority
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse on successful completion
err_timeout  out  1  one-cycle pulse on handshake timeout
err_len  out  1  one-cycle pulse when start is rejected for len > MAX_LEN
buf_rd_en  out  1  buffer read strobe; data is valid the next cycle
buf_addr  out  ADDR_W  payload byte index 0..len-1
buf_data  in  8  buffer read data
syn_gen_ld  out  1  to usb_top SYN_GEN_LD
crc_16  out  1  to usb_top CRC_16
tx_load  out  1  to usb_top TX_LOAD
tx_data  out  8  to usb_top TX_DATA
tx_last_byte  out  1  to usb_top TX_LAST_BYTE
tx_ready_ld  in  1  from usb_top TX_READY_LD
t_lastbit  in  1  from usb_top T_lastbit

Behaviour:
- Reset: every output is 0 (tx_data 8'h00, buf_addr 0). FSM goes to IDLE; the byte index and timeout counter clear.
- All outputs are registered. Pulses (syn_gen_ld, tx_load, tx_last_byte, done, err_*) are exactly 1 cycle wide.
- IDLE: start with len <= MAX_LEN latches pid, len and crc16_sel, sets busy, and goes to SYNC. Start with len > MAX_LEN pulses err_len and stays in IDLE. crc_16 takes the latched crc16_sel and holds it until the next accepted start.
- SYNC: syn_gen_ld = 1 for one cycle, then go to WAIT_PID.
- WAIT_PID: on a cycle with tx_ready_ld = 1, the next cycle has tx_load = 1 and tx_data = pid, then go to HOLD.
- HOLD: one cycle in which tx_ready_ld is ignored, covering usb_top's deassert latency.
  - Next state is FETCH if payload bytes remain.
  - Otherwise next state is WAIT_LAST.
- FETCH: buf_rd_en = 1 with buf_addr = idx. The next cycle captures buf_data into a holding register, then go to WAIT_DATA.
- WAIT_DATA: on tx_ready_ld = 1, tx_load = 1 with the captured byte for one cycle, idx increments, then go to HOLD.
- WAIT_LAST: on tx_ready_ld = 1, tx_last_byte = 1 for one cycle, then go to DRAIN.
- DRAIN: on t_lastbit = 1, done pulses, busy falls in the same cycle, and the FSM returns to IDLE.
- len = 0: the sequence is SYNC, PID byte, WAIT_LAST, DRAIN. There is no buffer read.
- Timeout:
  - A counter clears on entry to WAIT_PID, WAIT_DATA, WAIT_LAST and DRAIN.
  - When it reaches TIMEOUT-1 without the awaited input, err_timeout pulses and the FSM goes to IDLE.
  - tx_last_byte is never issued after a timeout.
- abort = 1 in any non-IDLE state: next cycle the FSM is in IDLE, busy = 0, and all strobes are 0. There is no done and no err pulse. abort in IDLE has no effect.
- Simultaneous events:
  - abort beats timeout, which beats the handshake.
  - start while busy is ignored and produces no error.
- tx_data holds its last value between loads; it is not forced to 0.

Decomposition:
- Package usb_seq_pkg holds:
  - state enum (IDLE, SYNC, WAIT_PID, HOLD, FETCH, WAIT_DATA, WAIT_LAST, DRAIN);
  - PID constants (DATA0 8'hC3, DATA1 8'h4B, IN 8'h69, OUT 8'hE1);
  - default TIMEOUT.
- One sub-module: usb_seq_timer, a clearable saturating counter with terminal-count output, instantiated once.

Test Plan:
- PID 8'hC3, len 2, crc16_sel 1, buffer {8'h3F, 8'hB4}, usb_top model raising tx_ready_ld every 8 cycles -> syn_gen_ld once; tx_load pulses carry C3, 3F, B4 in order; crc_16 = 1 throughout; one tx_last_byte; done after t_lastbit; buf_addr sequence 0, 1.
- PID 8'h69, len 0, crc16_sel 0 -> no buf_rd_en; one tx_load with 8'h69; tx_last_byte; done; crc_16 = 0.
- len 2, tx_ready_ld held low after the PID load -> err_timeout exactly TIMEOUT cycles after entering WAIT_DATA; no tx_last_byte; busy = 0 next cycle.
- abort asserted in the cycle after the second tx_load of a len 4 packet -> IDLE next cycle; no done or err pulse; a new start then completes a full packet normally.
- start with len 65 (MAX_LEN 64) -> err_len pulse, busy stays 0. start pulsed again mid-packet -> ignored; the packet completes unchanged.
- reset_l asserted mid-WAIT_DATA -> all outputs 0 immediately (asynchronously); after release, a start is accepted and buf_addr begins at 0.
